chebyshev_feeder: RTL and testbench

Sequencer on the driving side of `chebyshev_computation`. It holds a coefficient table loaded over a simple write port. On `start` it streams one operand `x` with coefficients c0..c(N-1) into the core, one term per cycle, then waits out the core latency. It then captures the core's `data_out` as the result and pulses `done`. It replaces the hand-written stimulus used during bring-up and sits between the control host and the core.

---
 rtl/chebyshev_feeder_pkg.sv | 21 ++
 rtl/chebyshev_feeder_if.sv | 37 +++
 rtl/chebyshev_coeff_rf.sv | 30 +++
 rtl/chebyshev_feeder.sv | 116 +++++++++++
 tb/tb_chebyshev_feeder.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/chebyshev_feeder_pkg.sv
// rtl/chebyshev_feeder_pkg.sv - shared state encodings, widths and clog2 for the feeder
package chebyshev_feeder_pkg;

   localparam int WL_DEFAULT = 4;
   localparam int CL_DEFAULT = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/chebyshev_feeder_if.sv
// rtl/chebyshev_feeder_if.sv - host, coefficient-port and core-side signals of the feeder
interface chebyshev_feeder_if #(
   parameter int WL    = chebyshev_feeder_pkg::WL_DEFAULT,
   parameter int CL    = chebyshev_feeder_pkg::CL_DEFAULT,
   parameter int ORDER = 8
);
   import chebyshev_feeder_pkg::*;

   localparam int AW = clog2(ORDER);

   logic                 cfg_we;
   logic [AW-1:0]        cfg_addr;
   logic signed [CL-1:0] cfg_coeff;
   logic                 start;
   logic signed [WL-1:0] x_in;
   logic [AW:0]          n_terms;
   logic signed [WL-1:0] core_data_in;
   logic signed [CL-1:0] core_coeff_in;
   logic                 core_valid;
   logic                 core_first;
   logic signed [WL-1:0] core_data_out;
   logic                 busy;
   logic                 done;
   logic signed [WL-1:0] result;

   // master is the host plus core side; slave is the feeder itself
   modport master (
      output cfg_we, cfg_addr, cfg_coeff, start, x_in, n_terms, core_data_out,
      input  core_data_in, core_coeff_in, core_valid, core_first, busy, done, result
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_coeff, start, x_in, n_terms, core_data_out,
      output core_data_in, core_coeff_in, core_valid, core_first, busy, done, result
   );

endinterface

// File: rtl/chebyshev_coeff_rf.sv
// rtl/chebyshev_coeff_rf.sv - ORDER x CL coefficient register file, async clear, comb read
module chebyshev_coeff_rf
   import chebyshev_feeder_pkg::*;
#(
   parameter int CL    = CL_DEFAULT,
   parameter int ORDER = 8,
   parameter int AW    = clog2(ORDER)
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 we,
   input  logic [AW-1:0]        waddr,
   input  logic signed [CL-1:0] wdata,
   input  logic [AW-1:0]        raddr,
   output logic signed [CL-1:0] rdata
);

   logic signed [CL-1:0] mem_q [ORDER];

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < ORDER; i++) mem_q[i] <= '0;
      end else if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/chebyshev_feeder.sv
// rtl/chebyshev_feeder.sv - streams x and c0..c(N-1) into the core, then captures its result
module chebyshev_feeder
   import chebyshev_feeder_pkg::*;
#(
   parameter int WL       = WL_DEFAULT,
   parameter int CL       = CL_DEFAULT,
   parameter int ORDER    = 8,
   parameter int CORE_LAT = 2
) (
   input logic               clock,
   input logic               resetn,
   chebyshev_feeder_if.slave bus
);

   localparam int              AW       = clog2(ORDER);
   localparam int              LW       = clog2(CORE_LAT + 1);
   localparam logic [AW:0]     N_MAX    = (AW + 1)'(ORDER);
   localparam logic [LW-1:0]   LAT_INIT = LW'(CORE_LAT - 1);

   state_e               state_q, state_d;
   logic signed [WL-1:0] x_q, x_d;
   logic signed [WL-1:0] result_q, result_d;
   logic [AW:0]          n_q, n_d;
   logic [AW-1:0]        k_q, k_d;
   logic [LW-1:0]        lat_q, lat_d;

   logic                 busy;
   logic                 streaming;
   logic [AW:0]          n_sat;
   logic signed [CL-1:0] rd_coeff;

   assign busy      = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
   assign streaming = (state_q == ST_STREAM);
   assign n_sat     = (bus.n_terms > N_MAX) ? N_MAX : bus.n_terms;

   // Writes landing with an accepted start are visible from the first STREAM read.
   chebyshev_coeff_rf #(.CL(CL), .ORDER(ORDER), .AW(AW)) u_coeff_rf (
      .clock (clock),
      .resetn(resetn),
      .we    (bus.cfg_we && !busy),
      .waddr (bus.cfg_addr),
      .wdata (bus.cfg_coeff),
      .raddr (k_q),
      .rdata (rd_coeff)
   );

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      result_d = result_q;
      n_d      = n_q;
      k_d      = k_q;
      lat_d    = lat_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (bus.start) begin
               if (n_sat == '0) begin
                  state_d  = ST_DONE;
                  result_d = '0;
               end else begin
                  state_d = ST_STREAM;
                  x_d     = bus.x_in;
                  n_d     = n_sat;
                  k_d     = '0;
               end
            end
         end
         ST_STREAM: begin
            k_d = k_q + AW'(1);
            if (({1'b0, k_q} + (AW + 1)'(1)) == n_q) begin
               state_d = ST_DRAIN;
               k_d     = '0;
               lat_d   = LAT_INIT;
            end
         end
         ST_DRAIN: begin
            if (lat_q == '0) begin
               state_d  = ST_DONE;
               result_d = bus.core_data_out;
            end else begin
               lat_d = lat_q - LW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         x_q      <= '0;
         result_q <= '0;
         n_q      <= '0;
         k_q      <= '0;
         lat_q    <= '0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         result_q <= result_d;
         n_q      <= n_d;
         k_q      <= k_d;
         lat_q    <= lat_d;
      end
   end

   // Outside STREAM the core sees zeros so a free-running accumulator stays put.
   assign bus.core_valid    = streaming;
   assign bus.core_first    = streaming && (k_q == '0);
   assign bus.core_data_in  = streaming ? x_q : '0;
   assign bus.core_coeff_in = streaming ? rd_coeff : '0;
   assign bus.busy          = busy;
   assign bus.done          = (state_q == ST_DONE);
   assign bus.result        = result_q;

endmodule

// File: tb/tb_chebyshev_feeder.sv
// tb/tb_chebyshev_feeder.sv - directed table-driven bench for chebyshev_feeder
module tb_chebyshev_feeder;

   localparam int WL       = 4;
   localparam int CL       = 4;
   localparam int ORDER    = 8;
   localparam int CORE_LAT = 2;

   logic clock  = 1'b0;
   logic resetn = 1'b0;

   chebyshev_feeder_if #(.WL(WL), .CL(CL), .ORDER(ORDER)) bus ();

   chebyshev_feeder #(.WL(WL), .CL(CL), .ORDER(ORDER), .CORE_LAT(CORE_LAT)) dut (
      .clock (clock),
      .resetn(resetn),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   // stand-in core: 2.2 fixed-point multiply-accumulate plus one output register
   logic signed [3:0] acc  = '0;
   logic signed [3:0] dout = '0;
   logic signed [3:0] term;
   assign term = 4'((int'(bus.core_data_in) * int'(bus.core_coeff_in)) >>> 2);
   always @(posedge clock) begin
      if (bus.core_valid) acc <= bus.core_first ? term : acc + term;
      dout <= acc;
   end
   assign bus.core_data_out = dout;

   int n_cmp = 0;
   int n_bad = 0;
   logic signed [3:0] coeff_model [8];

   typedef struct {
      logic signed [3:0] x;
      logic [3:0]        n;
      bit                wr;
      logic [2:0]        wa;
      logic signed [3:0] wv;
      bit                inj;
      int                terms;
      int                dcyc;
      int                res;
   } vec_t;

   vec_t tbl [9];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic write_coeff(input logic [2:0] a, input logic signed [3:0] v);
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = a;
      bus.cfg_coeff = v;
      coeff_model[a] = v;
      @(posedge clock); #1;
      bus.cfg_we = 1'b0;
   endtask

   task automatic run_eval(input logic signed [3:0] x, input logic [3:0] n,
                           input bit wr, input logic [2:0] wa, input logic signed [3:0] wv,
                           input bit inj,
                           output int terms, output int dcyc, output int fcyc,
                           output int nfirst, output int cerr, output int ierr, output int res);
      terms = 0; dcyc = -1; fcyc = -1; nfirst = 0; cerr = 0; ierr = 0; res = 0;
      bus.start     = 1'b1;
      bus.x_in      = x;
      bus.n_terms   = n;
      bus.cfg_we    = wr;
      bus.cfg_addr  = wa;
      bus.cfg_coeff = wv;
      if (wr) coeff_model[wa] = wv;
      @(posedge clock); #1;
      bus.start  = 1'b0;
      bus.cfg_we = 1'b0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clock);
         if (bus.core_valid === 1'b1) begin
            if (terms == 0) fcyc = cyc;
            if (bus.core_first === 1'b1) begin
               nfirst++;
               if (terms != 0) cerr++;
            end
            if (bus.core_data_in !== x || bus.core_coeff_in !== coeff_model[terms[2:0]]) cerr++;
            terms++;
         end else if (bus.core_data_in !== 4'sd0 || bus.core_coeff_in !== 4'sd0 ||
                      bus.core_first !== 1'b0) begin
            ierr++;
         end
         if (bus.done === 1'b1) begin
            dcyc = cyc;
            res  = int'(bus.result);
            break;
         end
         if (inj && cyc == 1) begin
            bus.cfg_we    = 1'b1;
            bus.cfg_addr  = 3'd0;
            bus.cfg_coeff = 4'sd7;
            bus.start     = 1'b1;
            bus.x_in      = 4'sd4;
            bus.n_terms   = 4'd1;
         end
         @(posedge clock); #1;
         bus.cfg_we = 1'b0;
         bus.start  = 1'b0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int terms, dcyc, fcyc, nfirst, cerr, ierr, res, done_seen;
      logic signed [3:0] init_c [8];
      init_c = '{4'sd2, 4'sd4, -4'sd1, 4'sd3, -4'sd8, 4'sd7, 4'sd1, -4'sd3};

      tbl[0] = '{x: 4'sd4,  n: 4'd2,  wr: 1'b0, wa: 3'd0, wv: 4'sd0, inj: 1'b0, terms: 2, dcyc: 5,  res: 6};
      tbl[1] = '{x: 4'sd4,  n: 4'd0,  wr: 1'b0, wa: 3'd0, wv: 4'sd0, inj: 1'b0, terms: 0, dcyc: 1,  res: 0};
      tbl[2] = '{x: 4'sd4,  n: 4'd15, wr: 1'b0, wa: 3'd0, wv: 4'sd0, inj: 1'b0, terms: 8, dcyc: 11, res: 5};
      tbl[3] = '{x: 4'sd4,  n: 4'd8,  wr: 1'b0, wa: 3'd0, wv: 4'sd0, inj: 1'b0, terms: 8, dcyc: 11, res: 5};
      tbl[4] = '{x: -4'sd4, n: 4'd3,  wr: 1'b0, wa: 3'd0, wv: 4'sd0, inj: 1'b0, terms: 3, dcyc: 6,  res: -5};
      tbl[5] = '{x: 4'sd4,  n: 4'd3,  wr: 1'b0, wa: 3'd0, wv: 4'sd0, inj: 1'b1, terms: 3, dcyc: 6,  res: 5};
      tbl[6] = '{x: 4'sd4,  n: 4'd1,  wr: 1'b0, wa: 3'd0, wv: 4'sd0, inj: 1'b0, terms: 1, dcyc: 4,  res: 2};
      tbl[7] = '{x: 4'sd4,  n: 4'd4,  wr: 1'b1, wa: 3'd3, wv: 4'sd5, inj: 1'b0, terms: 4, dcyc: 7,  res: -6};
      tbl[8] = '{x: 4'sd4,  n: 4'd8,  wr: 1'b0, wa: 3'd0, wv: 4'sd0, inj: 1'b0, terms: 8, dcyc: 11, res: 7};

      bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_coeff = '0;
      bus.start = 1'b0; bus.x_in = '0; bus.n_terms = '0;
      for (int i = 0; i < 8; i++) coeff_model[i] = 4'sd0;

      repeat (2) @(posedge clock);
      #1;
      check("reset_outputs", int'({bus.busy, bus.done, bus.core_valid, bus.core_first,
                                   bus.core_data_in, bus.core_coeff_in, bus.result}), 0);
      resetn = 1'b1;
      @(posedge clock); #1;

      for (int i = 0; i < 8; i++) write_coeff(3'(i), init_c[i]);

      for (int i = 0; i < 9; i++) begin
         run_eval(tbl[i].x, tbl[i].n, tbl[i].wr, tbl[i].wa, tbl[i].wv, tbl[i].inj,
                  terms, dcyc, fcyc, nfirst, cerr, ierr, res);
         check($sformatf("row%0d_terms", i), terms, tbl[i].terms);
         check($sformatf("row%0d_done_cycle", i), dcyc, tbl[i].dcyc);
         check($sformatf("row%0d_result", i), res, tbl[i].res);
         check($sformatf("row%0d_first_cycle", i), fcyc, (tbl[i].terms > 0) ? 1 : -1);
         check($sformatf("row%0d_first_count", i), nfirst, (tbl[i].terms > 0) ? 1 : 0);
         check($sformatf("row%0d_coeff_stream", i), cerr, 0);
         check($sformatf("row%0d_idle_outputs", i), ierr, 0);
         @(posedge clock); #1;
         check($sformatf("row%0d_back_to_idle", i), int'({bus.busy, bus.done}), 0);
      end

      // back-to-back: second start lands in the DONE cycle of the first
      run_eval(4'sd4, 4'd2, 1'b0, 3'd0, 4'sd0, 1'b0, terms, dcyc, fcyc, nfirst, cerr, ierr, res);
      check("b2b_first_done", dcyc, 5);
      check("b2b_first_result", res, 6);
      run_eval(-4'sd4, 4'd2, 1'b0, 3'd0, 4'sd0, 1'b0, terms, dcyc, fcyc, nfirst, cerr, ierr, res);
      check("b2b_restart_cycle", fcyc, 1);
      check("b2b_first_flag", nfirst, 1);
      check("b2b_done_spacing", dcyc, 2 + CORE_LAT + 1);
      check("b2b_second_result", res, -6);
      check("b2b_coeff_stream", cerr, 0);
      @(posedge clock); #1;

      // reset in DRAIN: abort with no done, table cleared
      bus.start = 1'b1; bus.x_in = 4'sd4; bus.n_terms = 4'd2;
      @(posedge clock); #1;
      bus.start = 1'b0;
      repeat (2) begin
         @(posedge clock); #1;
      end
      check("drain_busy_before_reset", int'({bus.busy, bus.core_valid}), 2);
      resetn = 1'b0;
      #1;
      check("midreset_outputs", int'({bus.busy, bus.done, bus.core_valid, bus.core_first,
                                      bus.core_data_in, bus.core_coeff_in, bus.result}), 0);
      done_seen = 0;
      repeat (3) begin
         @(negedge clock);
         if (bus.done !== 1'b0) done_seen++;
      end
      resetn = 1'b1;
      repeat (2) begin
         @(negedge clock);
         if (bus.done !== 1'b0) done_seen++;
      end
      check("midreset_no_done", done_seen, 0);
      for (int i = 0; i < 8; i++) coeff_model[i] = 4'sd0;
      @(posedge clock); #1;
      run_eval(4'sd4, 4'd8, 1'b0, 3'd0, 4'sd0, 1'b0, terms, dcyc, fcyc, nfirst, cerr, ierr, res);
      check("readback_terms", terms, 8);
      check("readback_coeffs_zero", cerr, 0);
      check("readback_result", res, 0);
      check("readback_done_cycle", dcyc, 8 + CORE_LAT + 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
